// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: FSM state encodings, payload width, line levels and parity.
// UART_TX_BREAK_EN adds the BREAK state encoding.
package uart_pkg;

    localparam int DATA_W = 4;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
`ifdef UART_TX_BREAK_EN
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
`else
        ST_STOP   = 3'd4
`endif
    } tx_state_e;

    // Odd parity: ones in payload plus parity bit always total an odd number.
    function automatic logic odd_parity(input logic [DATA_W-1:0] d);
        return ~(^d);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: tick is high in the final clock cycle of each serial bit.
// clear holds the count at zero so the next bit starts a full period.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);

    logic [7:0] cnt_r;

    // Count 0..CLKS_PER_BIT-1, reloading at every bit boundary or when cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= 8'd0;
        end else if (clear || tick) begin
            cnt_r <= 8'd0;
        end else begin
            cnt_r <= cnt_r + 8'd1;
        end
    end

    assign tick = (cnt_r == LAST_CNT);

endmodule

// File: rtl/uart_parity_odd_tx.sv
// 4-bit UART transmitter with odd parity, MSB first, one stop bit.
// Define UART_TX_BREAK_EN to enable the send_break line-break feature.
import uart_pkg::*;

module uart_parity_odd_tx #(
    parameter int CLKS_PER_BIT = 1,
    parameter int BREAK_BITS   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data,
    input  logic              send,
    input  logic              send_break,
    output logic              ready,
    output logic              tx,
    output logic              done
);

    localparam logic [7:0] LAST_BRK = 8'(BREAK_BITS - 1);

    tx_state_e         state_r;
    tx_state_e         state_s;
    logic [1:0]        idx_r;
    logic [1:0]        idx_s;
    logic [DATA_W-1:0] data_r;
    logic              tx_r;
    logic              tx_s;
    logic              tick_s;
    logic              clear_s;
    logic              accept_data_s;
`ifdef UART_TX_BREAK_EN
    logic              accept_brk_s;
    logic [7:0]        brk_cnt_r;
`else
    logic              unused_s;

    assign unused_s = ^{send_break, LAST_BRK};
`endif

    // The bit timer idles at zero so an accepted frame gets a full start bit.
    assign clear_s = (state_r == ST_IDLE);

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .reset (reset),
        .clear (clear_s),
        .tick  (tick_s)
    );

    // Next-state, handshake decode and request acceptance.
    always_comb begin
        state_s       = state_r;
        idx_s         = idx_r;
        ready         = 1'b0;
        done          = 1'b0;
        accept_data_s = 1'b0;
`ifdef UART_TX_BREAK_EN
        accept_brk_s  = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                ready = 1'b1;
            end
            ST_START: begin
                if (tick_s) begin
                    state_s = ST_DATA;
                    idx_s   = 2'd3;
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    if (idx_r == 2'd0) begin
                        state_s = ST_PARITY;
                    end else begin
                        idx_s = idx_r - 2'd1;
                    end
                end else begin
                    idx_s = idx_r;
                end
            end
            ST_PARITY: begin
                if (tick_s) begin
                    state_s = ST_STOP;
                end else begin
                    state_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (tick_s) begin
                    state_s = ST_IDLE;
                    ready   = 1'b1;
                    done    = 1'b1;
                end else begin
                    state_s = ST_STOP;
                end
            end
`ifdef UART_TX_BREAK_EN
            ST_BREAK: begin
                if (tick_s && (brk_cnt_r == LAST_BRK)) begin
                    state_s = ST_IDLE;
                    ready   = 1'b1;
                    done    = 1'b1;
                end else begin
                    state_s = ST_BREAK;
                end
            end
`endif
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // A request accepted in a frame's final cycle chains without an idle gap.
        if (ready) begin
`ifdef UART_TX_BREAK_EN
            if (send_break) begin
                accept_brk_s = 1'b1;
                state_s      = ST_BREAK;
            end else if (send) begin
                accept_data_s = 1'b1;
                state_s       = ST_START;
            end else begin
                accept_data_s = 1'b0;
            end
`else
            if (send) begin
                accept_data_s = 1'b1;
                state_s       = ST_START;
            end else begin
                accept_data_s = 1'b0;
            end
`endif
        end else begin
            accept_data_s = 1'b0;
        end
    end

    // Line level for the upcoming cycle, registered below so tx never glitches.
    always_comb begin
        tx_s = LINE_IDLE;
        case (state_s)
            ST_IDLE:   tx_s = LINE_IDLE;
            ST_START:  tx_s = LINE_START;
            ST_DATA:   tx_s = data_r[idx_s];
            ST_PARITY: tx_s = odd_parity(data_r);
            ST_STOP:   tx_s = LINE_STOP;
`ifdef UART_TX_BREAK_EN
            ST_BREAK:  tx_s = LINE_START;
`endif
            default:   tx_s = LINE_IDLE;
        endcase
    end

    // FSM state, shift index, payload latch and serial line register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            idx_r   <= 2'd0;
            data_r  <= {DATA_W{1'b0}};
            tx_r    <= LINE_IDLE;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            tx_r    <= tx_s;
            if (accept_data_s) begin
                data_r <= data;
            end else begin
                data_r <= data_r;
            end
        end
    end

`ifdef UART_TX_BREAK_EN
    // Counts elapsed bit times while the break holds the line low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            brk_cnt_r <= 8'd0;
        end else if (accept_brk_s) begin
            brk_cnt_r <= 8'd0;
        end else if ((state_r == ST_BREAK) && tick_s) begin
            brk_cnt_r <= brk_cnt_r + 8'd1;
        end else begin
            brk_cnt_r <= brk_cnt_r;
        end
    end
`endif

    assign tx = tx_r;

endmodule

// File: tb/tb_uart_parity_odd_tx.sv
// Scoreboard bench for uart_parity_odd_tx: two instances (1 and 3 clocks per bit) against a
// frame-level model; break behaviour follows whether UART_TX_BREAK_EN is defined.
module tb_uart_parity_odd_tx;

    localparam int CPB_A = 1;
    localparam int BRK_A = 8;
    localparam int CPB_B = 3;
    localparam int BRK_B = 3;
`ifdef UART_TX_BREAK_EN
    localparam bit BRK_EN = 1'b1;
`else
    localparam bit BRK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] data = 4'd0;
    logic       send = 1'b0;
    logic       send_break = 1'b0;
    logic       ready_a, tx_a, done_a;
    logic       ready_b, tx_b, done_b;

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;

    // Each entry is one expected clock cycle: {last_cycle_of_frame, tx}.
    logic [1:0] q_a[$];
    logic [1:0] q_b[$];

    always #5 clk = ~clk;

    uart_parity_odd_tx #(.CLKS_PER_BIT(CPB_A), .BREAK_BITS(BRK_A)) dut_a (
        .clk(clk), .reset(reset), .data(data), .send(send), .send_break(send_break),
        .ready(ready_a), .tx(tx_a), .done(done_a)
    );

    uart_parity_odd_tx #(.CLKS_PER_BIT(CPB_B), .BREAK_BITS(BRK_B)) dut_b (
        .clk(clk), .reset(reset), .data(data), .send(send), .send_break(send_break),
        .ready(ready_b), .tx(tx_b), .done(done_b)
    );

    task automatic cmp(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: if the instance is free, queue the whole waveform of the request.
    task automatic offer(input int k);
        logic [1:0] seq[$];
        logic [1:0] last;
        logic [6:0] bits;
        logic       par;
        int         cpb;
        int         brk;
        int         busy;
        cpb  = (k == 0) ? CPB_A : CPB_B;
        brk  = (k == 0) ? BRK_A : BRK_B;
        busy = (k == 0) ? q_a.size() : q_b.size();
        if (busy == 0) begin
            if (BRK_EN && send_break) begin
                for (int i = 0; i < brk * cpb; i++) seq.push_back(2'b00);
            end else if (send) begin
                par  = ($countones(data) % 2 == 0) ? 1'b1 : 1'b0;
                bits = {1'b0, data[3], data[2], data[1], data[0], par, 1'b1};
                for (int b = 6; b >= 0; b--)
                    for (int c = 0; c < cpb; c++) seq.push_back({1'b0, bits[b]});
            end
            if (seq.size() > 0) begin
                last = seq.pop_back();
                seq.push_back({1'b1, last[0]});
            end
            foreach (seq[i]) begin
                if (k == 0) q_a.push_back(seq[i]);
                else        q_b.push_back(seq[i]);
            end
        end
    endtask

    task automatic mon_step(input int k, input logic tx_v, input logic rdy_v, input logic done_v);
        logic [1:0] e;
        logic       idle_next;
        e = 2'b01;
        if (k == 0) begin
            if (q_a.size() > 0) e = q_a.pop_front();
            idle_next = (q_a.size() == 0);
        end else begin
            if (q_b.size() > 0) e = q_b.pop_front();
            idle_next = (q_b.size() == 0);
        end
        cmp((k == 0) ? "tx_cpb1" : "tx_cpb3", tx_v, e[0]);
        cmp((k == 0) ? "done_cpb1" : "done_cpb3", done_v, e[1]);
        cmp((k == 0) ? "ready_cpb1" : "ready_cpb3", rdy_v, idle_next);
    endtask

    // Monitor: every cycle, pop the expected cycle for each instance and compare.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                mon_step(0, tx_a, ready_a, done_a);
                mon_step(1, tx_b, ready_b, done_b);
            end
        end
    end

    task automatic cycle(input logic s, input logic b, input logic [3:0] d);
        @(negedge clk);
        #2;
        send       = s;
        send_break = b;
        data       = d;
        offer(0);
        offer(1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'($urandom));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #2;
        cmp("reset_tx_cpb1", tx_a, 1'b1);
        cmp("reset_ready_cpb1", ready_a, 1'b1);
        cmp("reset_done_cpb1", done_a, 1'b0);
        cmp("reset_tx_cpb3", tx_b, 1'b1);
        reset  = 1'b0;
        mon_en = 1'b1;

        cycle(1'b1, 1'b0, 4'b0101);
        idle(24);
        cycle(1'b1, 1'b0, 4'b0111);
        idle(24);
        cycle(1'b1, 1'b0, 4'b1010);
        for (int i = 0; i < 13; i++) cycle(1'b1, 1'b0, 4'b0000);
        idle(45);
        cycle(1'b1, 1'b0, 4'b1000);
        idle(24);
        cycle(1'b1, 1'b1, 4'b0110);
        idle(30);

        // Abort a frame in DATA with reset, then accept on the first edge after release.
        cycle(1'b1, 1'b0, 4'b0110);
        idle(3);
        @(negedge clk);
        #2;
        reset      = 1'b1;
        send       = 1'b0;
        send_break = 1'b0;
        #1;
        cmp("midframe_reset_tx_cpb1", tx_a, 1'b1);
        cmp("midframe_reset_tx_cpb3", tx_b, 1'b1);
        cmp("midframe_reset_ready_cpb1", ready_a, 1'b1);
        q_a.delete();
        q_b.delete();
        @(negedge clk);
        #2;
        reset = 1'b0;
        send  = 1'b1;
        data  = 4'b1111;
        offer(0);
        offer(1);
        idle(24);

        for (int i = 0; i < 700; i++)
            cycle($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, 4'($urandom));
        idle(40);
        cmp("drained_cpb1", q_a.size() == 0, 1'b1);
        cmp("drained_cpb3", q_b.size() == 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_parity_odd_tx.md
UART_PARITY_ODD_TX -- requirements
Module: uart_parity_odd_tx

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 1, giving the clock cycles per serial bit (legal range 1..255).
REQ-002 The module SHALL have parameter BREAK_BITS, default 8, giving the bit times a break holds the line low (legal range 1..255).
REQ-003 The module SHALL have port clk  input  1  the single clock; all logic on posedge.
REQ-004 The module SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The module SHALL have port data  input  4  frame payload, sampled on acceptance.
REQ-006 The module SHALL have port send  input  1  request to transmit data.
REQ-007 The module SHALL have port send_break  input  1  request to transmit a break (used only when UART_TX_BREAK_EN is defined).
REQ-008 The module SHALL have port ready  output  1  high when a request is accepted this cycle.
REQ-009 The module SHALL have port tx  output  1  serial line; idle high.
REQ-010 The module SHALL have port done  output  1  one-cycle pulse in the final cycle of a stop bit or break.

Function
REQ-011 Frame order SHALL be: start (0), data[3], data[2], data[1], data[0], parity, stop (1), each held CLKS_PER_BIT cycles.
REQ-012 The parity bit SHALL be ~(^data), so the count of ones in data plus parity is odd.
REQ-013 States SHALL be IDLE, START, DATA, PARITY, STOP and BREAK; BREAK exists only when UART_TX_BREAK_EN is defined.
REQ-014 ready SHALL be high in IDLE and in the final cycle of STOP or BREAK, and low otherwise.
REQ-015 send and ready both high at a posedge SHALL latch data and enter START, so tx=0 from the next cycle (latency 1).
REQ-016 An acceptance in the final STOP cycle SHALL start the next frame with no idle gap.
REQ-017 data and send changes while ready is low SHALL be ignored; the latched data SHALL NOT change mid-frame.
REQ-018 DATA SHALL use a 2-bit index that counts from 3 down to 0 and SHALL exit to PARITY after index 0 without wrapping.
REQ-019 The bit-period counter SHALL count 0..CLKS_PER_BIT-1 and reload at each bit boundary; with CLKS_PER_BIT=1 every cycle is a boundary.
REQ-020 tx SHALL be registered and glitch-free, and SHALL be 1 in IDLE.
REQ-021 When send and send_break are both high with ready high, send_break SHALL win; the data frame SHALL NOT be sent.

Reset
REQ-022 Reset SHALL asynchronously force state=IDLE, tx=1, ready=1, done=0, counters=0 and latched data=0.
REQ-023 Reset mid-frame SHALL abort the frame, and tx SHALL return high within the same cycle.
REQ-024 The first acceptance SHALL be possible on the first posedge after reset deasserts.

Configuration
REQ-025 With macro UART_TX_BREAK_EN defined, send_break accepted with ready high SHALL hold tx=0 for BREAK_BITS*CLKS_PER_BIT cycles, then return to IDLE with done pulsed in the last break cycle.
REQ-026 Without UART_TX_BREAK_EN, the send_break port SHALL still exist but be ignored, and no BREAK state or break counter SHALL be synthesized.

Structure
REQ-027 Shared package uart_pkg (include file uart_pkg.vh) SHALL hold the state encodings, DATA_W=4, the START/STOP/IDLE line levels and the parity function.
REQ-028 The bit-period counter SHALL be a sub-module uart_baud_tick (parameter CLKS_PER_BIT; ports clk, reset, clear, tick).
REQ-029 The top-level FSM, shift index and parity generation SHALL reside in uart_parity_odd_tx.

Verification
REQ-030 Scenario: CLKS_PER_BIT=1, data=4'b0101, send pulse -> tx = 0,0,1,0,1,1,1 on consecutive cycles, with done in the stop cycle.
REQ-031 Scenario: data=4'b0111 -> tx = 0,0,1,1,1,0,1, with ready low for cycles 1-6 after acceptance.
REQ-032 Scenario: send held high with data 4'b1010 then 4'b0000 -> 14 cycles of tx = 0,1,0,1,0,1,1,0,0,0,0,0,1,1 with no idle gap.
REQ-033 Scenario: reset asserted during DATA -> tx=1 within the same cycle; after release, a new frame with data=4'b1111 gives 0,1,1,1,1,1,1.
REQ-034 Scenario: CLKS_PER_BIT=3, data=4'b1000 -> each bit held exactly 3 cycles, 21 cycles total, parity=0.
REQ-035 Scenario: UART_TX_BREAK_EN defined, BREAK_BITS=8, send and send_break both high -> tx=0 for 8 cycles, done on cycle 8, then tx=1 and ready=1.
